// File: rtl/poss_pkg.sv
// poss_pkg -- shared types and default widths for the power-on self-set
// table player.
//   poss_state_t : playback FSM states
//   poss_entry_t : one table entry {last, addr, data} at the default widths
package poss_pkg;

  localparam int POSS_ROM_AW_DEF = 6;
  localparam int POSS_ADDR_W_DEF = 16;
  localparam int POSS_DATA_W_DEF = 16;
  localparam int POSS_TO_CYC_DEF = 255;

  // Timeout counter width; covers the full TO_CYC range 1..65535.
  localparam int POSS_TO_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_WRITE,
    ST_DONE,
    ST_HOLD
  } poss_state_t;

  typedef struct packed {
    logic                       last;
    logic [POSS_ADDR_W_DEF-1:0] addr;
    logic [POSS_DATA_W_DEF-1:0] data;
  } poss_entry_t;

endpackage

// File: rtl/poss_table_player_if.sv
// poss_table_player_if -- table ROM read port plus register-bus write port.
//   rom_addr : table read address (player -> ROM)
//   rom_data : {last, addr, data}, valid one cycle after rom_addr (ROM -> player)
//   wr_req   : bus write request (player -> bus)
//   wr_addr  : bus write address (player -> bus)
//   wr_data  : bus write data (player -> bus)
//   wr_ack   : bus write accepted (bus -> player)
// Modports: master = the player, slave = ROM / register bus side.
interface poss_table_player_if #(
  parameter int ROM_AW = poss_pkg::POSS_ROM_AW_DEF,
  parameter int ADDR_W = poss_pkg::POSS_ADDR_W_DEF,
  parameter int DATA_W = poss_pkg::POSS_DATA_W_DEF
);

  logic [ROM_AW-1:0]        rom_addr;
  logic [ADDR_W+DATA_W:0]   rom_data;
  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ack;

  modport master (
    output rom_addr,
    input  rom_data,
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );

endinterface

// File: rtl/poss_table_player.sv
// poss_table_player -- walks an (address, data) initialisation table held in
// an external synchronous ROM and issues one register-bus write per entry
// while the loader holds run high. Ends with a one-cycle done pulse.
// Ports:
//   clk   : system clock
//   rst   : synchronous reset, active-high
//   run   : playback request level from the loader
//   bus   : ROM read port + register-bus write port (master side)
//   done  : one-cycle pulse at the end of a completed playback
//   error : sticky, a write timed out during the last playback
//   busy  : high in every state except IDLE and HOLD
module poss_table_player #(
  parameter int ROM_AW = poss_pkg::POSS_ROM_AW_DEF,
  parameter int ADDR_W = poss_pkg::POSS_ADDR_W_DEF,
  parameter int DATA_W = poss_pkg::POSS_DATA_W_DEF,
  parameter int TO_CYC = poss_pkg::POSS_TO_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  poss_table_player_if.master  bus,
  output logic                 done,
  output logic                 error,
  output logic                 busy
);

  import poss_pkg::*;

  localparam logic [ROM_AW-1:0]    IDX_MAX  = '1;
  localparam logic [POSS_TO_W-1:0] TO_LIMIT = POSS_TO_W'(TO_CYC);

  poss_state_t            state_q, state_d;
  logic                   run_q, run_qq;
  logic [ROM_AW-1:0]      index_q, index_d;
  logic [POSS_TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic                   last_q, last_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic                   error_q, error_d;
  // Set when run went low during a write; the handshake still completes,
  // but playback then returns to IDLE instead of continuing.
  logic                   abort_q, abort_d;

  logic                   run_rise;
  logic                   run_low;
  logic                   timeout;
  logic                   final_entry;
  logic                   ent_last;
  logic [ADDR_W-1:0]      ent_addr;
  logic [DATA_W-1:0]      ent_data;

  // Edge detection works on the registered copy of run, which is what
  // gives the FETCH-at-N+1 start latency.
  assign run_rise    = run_q & ~run_qq;
  assign run_low     = ~run_q;
  assign timeout     = (to_cnt_q == TO_LIMIT);
  // The top table slot ends playback even without its last flag, so the
  // index never wraps back to 0.
  assign final_entry = last_q | (index_q == IDX_MAX);

  assign ent_last = bus.rom_data[ADDR_W+DATA_W];
  assign ent_addr = bus.rom_data[ADDR_W+DATA_W-1 -: ADDR_W];
  assign ent_data = bus.rom_data[DATA_W-1:0];

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    to_cnt_d  = to_cnt_q;
    last_d    = last_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    error_d   = error_q;
    abort_d   = abort_q;

    unique case (state_q)
      ST_IDLE: begin
        index_d = '0;
        if (run_rise) begin
          error_d = 1'b0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (run_low) begin
          index_d = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        if (run_low) begin
          index_d = '0;
          state_d = ST_IDLE;
        end else begin
          last_d    = ent_last;
          wr_addr_d = ent_addr;
          wr_data_d = ent_data;
          to_cnt_d  = '0;
          abort_d   = 1'b0;
          state_d   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (run_low) begin
          abort_d = 1'b1;
        end
        // Ack is tested before the timeout so a coincident ack wins.
        if (bus.wr_ack) begin
          if (abort_q || run_low) begin
            index_d = '0;
            state_d = ST_IDLE;
          end else if (final_entry) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + ROM_AW'(1);
            state_d = ST_FETCH;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          if (abort_q || run_low) begin
            index_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          to_cnt_d = to_cnt_q + POSS_TO_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (run_low) begin
          index_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        index_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      run_qq    <= 1'b0;
      index_q   <= '0;
      to_cnt_q  <= '0;
      last_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      error_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run;
      run_qq    <= run_q;
      index_q   <= index_d;
      to_cnt_q  <= to_cnt_d;
      last_q    <= last_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      error_q   <= error_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.rom_addr = index_q;
  assign bus.wr_req   = (state_q == ST_WRITE);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign done         = (state_q == ST_DONE);
  assign error        = error_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_HOLD);

endmodule
